// File: rtl/commit_writeback_queue.sv
// In-order retire buffer: entries are allocated in program order, completed out of order by tag,
// and drained in order onto a registered regfile write port.
module commit_writeback_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int TAG_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_valid,
   input  logic [4:0]         alloc_rd,
   output logic               alloc_ready,
   output logic [TAG_W-1:0]   alloc_tag,
   input  logic               cpl_valid,
   input  logic [TAG_W-1:0]   cpl_tag,
   input  logic [WIDTH-1:0]   cpl_data,
   input  logic               flush,
   output logic               w_en,
   output logic [4:0]         rd_addr,
   output logic [WIDTH-1:0]   w_data,
   output logic               empty,
   output logic [TAG_W:0]     count
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]   busy;
   logic [DEPTH-1:0]   done;
   logic [4:0]         rd_mem   [DEPTH];
   logic [WIDTH-1:0]   data_mem [DEPTH];
   logic [TAG_W-1:0]   head;
   logic [TAG_W-1:0]   tail;
   logic [TAG_W:0]     count_q;

   logic alloc_fire;
   logic cpl_fire;
   logic commit_fire;

   // Handshake: an allocation transfers on a cycle where alloc_valid and alloc_ready are both
   // high; alloc_ready/alloc_tag depend only on registered state, so a same-cycle commit never
   // frees a slot for that cycle's allocation. Completions have no back-pressure.
   assign alloc_ready = (count_q != FULL_COUNT);
   assign alloc_tag   = tail;
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign cpl_fire    = cpl_valid & busy[cpl_tag];
   assign commit_fire = busy[head] & done[head];
   assign empty       = (count_q == '0);
   assign count       = count_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy    <= '0;
         done    <= '0;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (cpl_fire) begin
            done[cpl_tag] <= 1'b1;
         end
         if (commit_fire) begin
            busy[head] <= 1'b0;
            head       <= head + TAG_W'(1);
         end
         // The tail slot is never busy when allocation fires, so it cannot collide with cpl_fire.
         if (alloc_fire) begin
            busy[tail] <= 1'b1;
            done[tail] <= 1'b0;
            tail       <= tail + TAG_W'(1);
         end
         if (alloc_fire && !commit_fire) begin
            count_q <= count_q + (TAG_W+1)'(1);
         end else if (!alloc_fire && commit_fire) begin
            count_q <= count_q - (TAG_W+1)'(1);
         end
      end
   end

   // Payload storage needs no reset; busy/done qualify every read.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (cpl_fire) begin
            data_mem[cpl_tag] <= cpl_data;
         end
         if (alloc_fire) begin
            rd_mem[tail] <= alloc_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_en    <= 1'b0;
         rd_addr <= '0;
         w_data  <= '0;
      end else if (flush) begin
         w_en <= 1'b0;
      end else if (commit_fire) begin
         // x0 retires like any other entry but never writes the regfile.
         w_en    <= (rd_mem[head] != 5'd0);
         rd_addr <= rd_mem[head];
         w_data  <= data_mem[head];
      end else begin
         w_en <= 1'b0;
      end
   end

endmodule
